// File: rtl/aurora_sync_ctrl.sv
// rtl/aurora_sync_ctrl.sv - frame-alignment controller for a bank of 66b sync-header seekers
// Restarts seekers, picks the lowest eligible one, confirms its offset, then guards lock with header checks.
module aurora_sync_ctrl #(
  parameter int N_SEEKERS      = 4,
  parameter int RST_CYCLES     = 4,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int CONFIRM_FRAMES = 8,
  parameter int WINDOW_FRAMES  = 64,
  parameter int BAD_HDR_MAX    = 16,
  localparam int WW            = (N_SEEKERS > 1) ? $clog2(N_SEEKERS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     buffer_dv_i,
  input  logic [66:0]              buffer_slice_i,
  input  logic [N_SEEKERS-1:0]     seeker_synced_i,
  input  logic [7*N_SEEKERS-1:0]   seeker_offset_i,
  output logic                     seeker_rst_o,
  output logic                     locked_o,
  output logic [6:0]               offset_o,
  output logic [WW-1:0]            winner_o,
  output logic [1:0]               state_o,
  output logic [7:0]               loss_cnt_o
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int TW  = $clog2(SEARCH_TIMEOUT + 1);
  localparam int CW  = $clog2(CONFIRM_FRAMES + 1);
  localparam int FW  = $clog2(WINDOW_FRAMES + 1);
  localparam int BW  = $clog2(BAD_HDR_MAX + 1);

  typedef enum logic [1:0] {
    ST_RESTART = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_seeker_rst;
  logic            r_locked;
  logic [6:0]      r_offset;
  logic [WW-1:0]   r_winner;
  logic [7:0]      r_loss;
  logic [RCW-1:0]  r_rst_cnt;
  logic [TW-1:0]   r_timer;
  logic [CW-1:0]   r_conf;
  logic [FW-1:0]   r_frames;
  logic [BW-1:0]   r_bad;

  logic [6:0]           w_off [N_SEEKERS];
  logic [N_SEEKERS-1:0] w_elig;
  logic                 w_any;
  logic [WW-1:0]        w_first;
  logic                 w_win_ok;
  logic [1:0]           w_hdr;
  logic                 w_hdr_bad;
  logic [BW-1:0]        w_bad_nxt;
  logic [FW-1:0]        w_frames_nxt;
  logic [CW-1:0]        w_conf_nxt;

  for (genvar k = 0; k < N_SEEKERS; k++) begin : g_seek
    assign w_off[k]  = seeker_offset_i[7*k +: 7];
    assign w_elig[k] = seeker_synced_i[k] && (w_off[k] <= 7'd65);
  end

  // Scan downward so the lowest eligible index is the last one recorded.
  always_comb begin
    w_any   = 1'b0;
    w_first = '0;
    for (int k = N_SEEKERS - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_any   = 1'b1;
        w_first = WW'(k);
      end
    end
  end

  assign w_win_ok     = w_elig[r_winner] && (w_off[r_winner] == r_offset);
  assign w_hdr        = {buffer_slice_i[r_offset + 7'd1], buffer_slice_i[r_offset]};
  assign w_hdr_bad    = (w_hdr[1] == w_hdr[0]);
  assign w_bad_nxt    = r_bad + BW'(w_hdr_bad);
  assign w_frames_nxt = r_frames + FW'(1);
  assign w_conf_nxt   = r_conf + CW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_RESTART;
      r_seeker_rst <= 1'b1;
      r_locked     <= 1'b0;
      r_offset     <= '0;
      r_winner     <= '0;
      r_loss       <= '0;
      r_rst_cnt    <= '0;
      r_timer      <= '0;
      r_conf       <= '0;
      r_frames     <= '0;
      r_bad        <= '0;
    end else begin
      case (r_state)
        ST_RESTART: begin
          if (r_rst_cnt == RCW'(RST_CYCLES - 1)) begin
            r_state      <= ST_SEARCH;
            r_seeker_rst <= 1'b0;
            r_timer      <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RCW'(1);
          end
        end
        ST_SEARCH: begin
          if (w_any) begin
            r_winner <= w_first;
            r_offset <= w_off[w_first];
            r_conf   <= '0;
            r_state  <= ST_CONFIRM;
          end else if (r_timer == TW'(SEARCH_TIMEOUT - 1)) begin
            r_state      <= ST_RESTART;
            r_seeker_rst <= 1'b1;
            r_rst_cnt    <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_CONFIRM: begin
          if (buffer_dv_i) begin
            if (w_win_ok) begin
              r_conf <= w_conf_nxt;
              if (w_conf_nxt == CW'(CONFIRM_FRAMES)) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_bad    <= '0;
                r_frames <= '0;
              end
            end else begin
              r_state <= ST_SEARCH;
              r_timer <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (buffer_dv_i) begin
            // Loss takes precedence over the window rollover on the same frame.
            if (w_bad_nxt == BW'(BAD_HDR_MAX)) begin
              r_state      <= ST_RESTART;
              r_locked     <= 1'b0;
              r_seeker_rst <= 1'b1;
              r_rst_cnt    <= '0;
              r_bad        <= '0;
              r_frames     <= '0;
              if (r_loss != 8'hFF) r_loss <= r_loss + 8'd1;
            end else if (w_frames_nxt == FW'(WINDOW_FRAMES)) begin
              r_bad    <= '0;
              r_frames <= '0;
            end else begin
              r_bad    <= w_bad_nxt;
              r_frames <= w_frames_nxt;
            end
          end
        end
        default: r_state <= ST_RESTART;
      endcase
    end
  end

  assign seeker_rst_o = r_seeker_rst;
  assign locked_o     = r_locked;
  assign offset_o     = r_offset;
  assign winner_o     = r_winner;
  assign state_o      = r_state;
  assign loss_cnt_o   = r_loss;

endmodule

// File: tb/tb_aurora_sync_ctrl.sv
// tb/tb_aurora_sync_ctrl.sv - scoreboard bench for aurora_sync_ctrl against a cycle-level behavioural model
module tb_aurora_sync_ctrl;
  localparam int N = 4, RSTC = 4, TMO = 4096, CONF = 8, WIN = 64, BADM = 16;

  logic        clk = 1'b0;
  logic        rst, dv;
  logic [66:0] slice;
  logic [3:0]  synced;
  logic [27:0] offs;
  logic        seeker_rst_o, locked_o;
  logic [6:0]  offset_o;
  logic [1:0]  winner_o, state_o;
  logic [7:0]  loss_cnt_o;

  always #5 clk = ~clk;

  aurora_sync_ctrl #(
    .N_SEEKERS(N), .RST_CYCLES(RSTC), .SEARCH_TIMEOUT(TMO),
    .CONFIRM_FRAMES(CONF), .WINDOW_FRAMES(WIN), .BAD_HDR_MAX(BADM)
  ) dut (
    .clk_i(clk), .rst_i(rst), .buffer_dv_i(dv), .buffer_slice_i(slice),
    .seeker_synced_i(synced), .seeker_offset_i(offs),
    .seeker_rst_o(seeker_rst_o), .locked_o(locked_o), .offset_o(offset_o),
    .winner_o(winner_o), .state_o(state_o), .loss_cnt_o(loss_cnt_o)
  );

  bit t_sync [N];
  int t_off  [N];

  // Model: phase 0..3 = restart/search/confirm/locked, m_age = clocks spent in the current phase.
  int m_ph, m_age, m_conf, m_bad, m_frames, m_loss, m_off, m_win;
  bit m_rst, m_lock;

  logic [20:0] exp_q [$];
  int checks = 0, errors = 0, cyc = 0;

  function automatic int first_elig();
    for (int k = 0; k < N; k++)
      if (t_sync[k] && t_off[k] <= 65) return k;
    return -1;
  endfunction

  task automatic model_step();
    int f, hdr;
    if (rst) begin
      m_ph = 0; m_age = 0; m_rst = 1; m_lock = 0; m_off = 0; m_win = 0; m_loss = 0;
      m_conf = 0; m_bad = 0; m_frames = 0;
      return;
    end
    case (m_ph)
      0: begin
        m_age++;
        if (m_age == RSTC) begin m_ph = 1; m_age = 0; m_rst = 0; end
      end
      1: begin
        f = first_elig();
        if (f >= 0) begin
          m_win = f; m_off = t_off[f]; m_conf = 0; m_ph = 2;
        end else begin
          m_age++;
          if (m_age == TMO) begin m_ph = 0; m_age = 0; m_rst = 1; end
        end
      end
      2: if (dv) begin
        if (t_sync[m_win] && t_off[m_win] <= 65 && t_off[m_win] == m_off) begin
          m_conf++;
          if (m_conf == CONF) begin m_ph = 3; m_lock = 1; m_bad = 0; m_frames = 0; end
        end else begin
          m_ph = 1; m_age = 0;
        end
      end
      default: if (dv) begin
        hdr = int'((slice >> m_off) & 67'd3);
        m_frames++;
        if (hdr == 0 || hdr == 3) m_bad++;
        if (m_bad == BADM) begin
          m_ph = 0; m_age = 0; m_rst = 1; m_lock = 0;
          if (m_loss < 255) m_loss++;
        end else if (m_frames == WIN) begin
          m_bad = 0; m_frames = 0;
        end
      end
    endcase
  endtask

  task automatic step();
    for (int k = 0; k < N; k++) begin
      synced[k]       = t_sync[k];
      offs[7*k +: 7]  = 7'(t_off[k]);
    end
    @(posedge clk);
    model_step();
    exp_q.push_back({m_rst, m_lock, 2'(m_ph), 7'(m_off), 2'(m_win), 8'(m_loss)});
    #1;
  endtask

  task automatic frame(input bit bad);
    logic [1:0] hv;
    dv = 1'b1;
    slice = {3'($urandom), $urandom, $urandom};
    if (bad) hv = $urandom_range(0, 1) ? 2'b00 : 2'b11;
    else     hv = $urandom_range(0, 1) ? 2'b01 : 2'b10;
    slice[m_off +: 2] = hv;
    step();
    dv = 1'b0;
    repeat ($urandom_range(0, 1)) begin
      slice = {3'($urandom), $urandom, $urandom};
      step();
    end
  endtask

  task automatic lock_on(input int k, input int off);
    for (int j = 0; j < N; j++) t_sync[j] = 0;
    t_sync[k] = 1; t_off[k] = off;
    for (int i = 0; i < 80 && m_ph != 3; i++) frame(0);
  endtask

  task automatic window_with_bad(input int nbad);
    bit bp [WIN];
    int cnt, r;
    for (int i = 0; i < WIN; i++) bp[i] = 0;
    cnt = 0;
    while (cnt < nbad) begin
      r = $urandom_range(0, WIN - 1);
      if (!bp[r]) begin bp[r] = 1; cnt++; end
    end
    for (int i = 0; i < WIN; i++) frame(bp[i]);
  endtask

  always @(negedge clk) begin
    logic [20:0] e, g;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {seeker_rst_o, locked_o, state_o, offset_o, winner_o, loss_cnt_o};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d got rst=%0b lock=%0b st=%0d off=%0d win=%0d loss=%0d exp rst=%0b lock=%0b st=%0d off=%0d win=%0d loss=%0d",
                 cyc, g[20], g[19], g[18:17], g[16:10], g[9:8], g[7:0],
                 e[20], e[19], e[18:17], e[16:10], e[9:8], e[7:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; dv = 1'b0; slice = '0;
    for (int k = 0; k < N; k++) begin t_sync[k] = 0; t_off[k] = 0; end
    repeat (3) step();
    rst = 1'b0;
    repeat (8) step();

    t_sync[0] = 1; t_off[0] = 70;
    repeat (5) step();

    t_sync[0] = 0;
    t_sync[1] = 1; t_off[1] = 17; t_sync[3] = 1; t_off[3] = 40;
    step();
    repeat (4) frame(0);
    t_off[1] = 18;
    frame(0);
    step();
    t_off[1] = 17;
    lock_on(1, 17);

    window_with_bad(15);
    for (int i = 0; i < 200 && m_ph == 3; i++) frame($urandom_range(0, 1));
    repeat (6) step();

    for (int k = 0; k < N; k++) t_sync[k] = 0;
    repeat (TMO + 12) step();

    t_sync[0] = 1; t_off[0] = 66;
    t_sync[2] = 1; t_off[2] = 65;
    for (int i = 0; i < 80 && m_ph != 3; i++) frame(0);
    for (int i = 0; i < WIN; i++) frame(i >= WIN - BADM);
    repeat (6) step();

    lock_on(2, 0);
    for (int i = 0; i < WIN - 1; i++) frame(i < BADM - 1);
    frame(0);
    frame(1);
    for (int i = 0; i < 200 && m_ph == 3; i++) frame(1);
    repeat (6) step();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        int k = $urandom_range(0, N - 1);
        t_sync[k] = $urandom_range(0, 1);
        t_off[k]  = $urandom_range(0, 70);
      end
      dv = $urandom_range(0, 1);
      slice = {3'($urandom), $urandom, $urandom};
      step();
    end
    dv = 1'b0;

    lock_on(3, 33);
    repeat (10) frame(0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (6) step();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue_left=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
